div_iter: RTL and testbench

//   Iterative restoring divider: the inverse partner of the multdiv adder/multiplier path.

---
 rtl/div_iter.sv | 97 +++++++++
 tb/tb_div_iter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per clock, with sign fix-up
// and divide-by-zero flag.
module div_iter #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             busy,
    output logic             exception
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t r_state, w_next;
    logic             w_accept, w_last, w_dvd_neg, w_dvs_neg, w_ge;
    logic [WIDTH-1:0] w_dvd_abs, w_dvs_abs, w_q_it, w_r_it;
    logic [WIDTH:0]   w_rs;
    logic [WIDTH-1:0] r_q, r_r, r_dvs, r_quot, r_rem;
    logic [CW-1:0]    r_count;
    logic             r_neg_q, r_neg_r, r_exc;

    assign w_dvd_neg = SIGNED && dividend[WIDTH-1];
    assign w_dvs_neg = SIGNED && divisor[WIDTH-1];
    assign w_dvd_abs = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_abs = w_dvs_neg ? -divisor : divisor;
    // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits
    // and the difference always fits WIDTH bits.
    assign w_rs   = {r_r, r_q[WIDTH-1]};
    assign w_ge   = w_rs >= {1'b0, r_dvs};
    assign w_r_it = w_ge ? w_rs[WIDTH-1:0] - r_dvs : w_rs[WIDTH-1:0];
    assign w_q_it = {r_q[WIDTH-2:0], w_ge};
    assign w_last = r_count == CW'(WIDTH - 1);

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign exception = r_exc;
    assign ready     = r_state == DONE;
    assign busy      = r_state != IDLE;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                w_accept = 1'b1;
                w_next   = divisor == '0 ? DONE : RUN;
            end
            RUN:     w_next = w_last ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q     <= '0;
            r_r     <= '0;
            r_dvs   <= '0;
            r_count <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_exc   <= 1'b0;
        end else if (w_accept) begin
            r_q     <= w_dvd_abs;
            r_r     <= '0;
            r_dvs   <= w_dvs_abs;
            r_count <= '0;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            if (divisor == '0) begin
                r_quot <= '0;
                r_rem  <= '0;
                r_exc  <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_q     <= w_q_it;
            r_r     <= w_r_it;
            r_count <= r_count + 1'b1;
            if (w_last) begin
                r_quot <= r_neg_q ? -w_q_it : w_q_it;
                r_rem  <= r_neg_r ? -w_r_it : w_r_it;
                r_exc  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: drives a signed and an unsigned div_iter with identical stimulus and
// checks both against 64-bit arithmetic.
module tb_div_iter;
    logic        clock, reset_n, start;
    logic [31:0] dividend, divisor;
    logic [31:0] q_s, r_s, q_u, r_u;
    logic        rdy_s, rdy_u, bsy_s, bsy_u, exc_s, exc_u;
    int vectors = 0, miscompares = 0;

    div_iter #(.WIDTH(32), .SIGNED(1'b1)) u_s (
        .clock(clock), .reset_n(reset_n), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(q_s), .remainder(r_s), .ready(rdy_s), .busy(bsy_s), .exception(exc_s));
    div_iter #(.WIDTH(32), .SIGNED(1'b0)) u_u (
        .clock(clock), .reset_n(reset_n), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(q_u), .remainder(r_u), .ready(rdy_u), .busy(bsy_u), .exception(exc_u));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sg,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
        longint la, lb;
        if (b == 0) begin
            q = 0; r = 0; e = 1'b1;
        end else begin
            la = sg ? longint'($signed(a)) : longint'({32'b0, a});
            lb = sg ? longint'($signed(b)) : longint'({32'b0, b});
            q  = 32'(la / lb);
            r  = 32'(la % lb);
            e  = 1'b0;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int poke_at,
                          input bit do_reset);
        int n, seen;
        logic [31:0] eq_s, er_s, eq_u, er_u;
        logic ee_s, ee_u;
        model(a, b, 1'b1, eq_s, er_s, ee_s);
        model(a, b, 1'b0, eq_u, er_u, ee_u);
        @(negedge clock);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        n = 1;
        if (do_reset) begin
            repeat (11) @(negedge clock);
            reset_n = 1'b0;
            #1;
            chk("rst_q", q_s | q_u, 0);
            chk("rst_r", r_s | r_u, 0);
            chk("rst_flags", {26'b0, rdy_s, rdy_u, bsy_s, bsy_u, exc_s, exc_u}, 0);
            repeat (2) @(negedge clock);
            reset_n = 1'b1;
            seen = 0;
            repeat (40) begin
                @(negedge clock);
                seen += int'(rdy_s | rdy_u);
            end
            chk("rst_no_ready", 32'(seen), 0);
            return;
        end
        if (b != 0) chk("busy_run", {31'b0, bsy_s & bsy_u}, 1);
        while (!rdy_s && n < 100) begin
            if (n == poke_at) begin
                start = 1'b1; dividend = 9; divisor = 9;
            end
            @(negedge clock);
            start = 1'b0;
            n++;
        end
        chk("latency", 32'(n), b == 0 ? 1 : 33);
        chk("ready_u", {31'b0, rdy_u}, 1);
        chk("q_signed", q_s, eq_s);
        chk("r_signed", r_s, er_s);
        chk("exc_signed", {31'b0, exc_s}, {31'b0, ee_s});
        chk("q_unsigned", q_u, eq_u);
        chk("r_unsigned", r_u, er_u);
        chk("exc_unsigned", {31'b0, exc_u}, {31'b0, ee_u});
        @(negedge clock);
        chk("ready_pulse", {30'b0, rdy_s, rdy_u}, 0);
        chk("busy_clear", {30'b0, bsy_s, bsy_u}, 0);
        chk("q_hold", q_s, eq_s);
    endtask

    initial begin
        logic [31:0] a, b;
        reset_n = 1'b0; start = 1'b0; dividend = 0; divisor = 0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset_q", q_s | q_u, 0);
        chk("reset_r", r_s | r_u, 0);
        chk("reset_flags", {26'b0, rdy_s, rdy_u, bsy_s, bsy_u, exc_s, exc_u}, 0);
        run_op(100, 7, 0, 1'b0);
        run_op(-32'sd7, 2, 0, 1'b0);
        run_op(7, -32'sd2, 0, 1'b0);
        run_op(-32'sd7, -32'sd2, 0, 1'b0);
        run_op(32'h1234, 0, 0, 1'b0);
        run_op(10, 5, 0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 1, 0, 1'b0);
        run_op(1000, 3, 10, 1'b0);
        run_op(50, 5, 0, 1'b1);
        run_op(50, 5, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 0;
                1:       b = $urandom_range(1, 15);
                2:       b = -32'($urandom_range(1, 15));
                3:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            if (i % 5 == 0) a = 32'h8000_0000;
            run_op(a, b, 0, 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
